// File: rtl/mips_regfile_mp.sv
// mips_regfile_mp
// ---------------------------------------------------------------------------
// MIPS general-purpose register file with several read ports, one byte-masked
// write port, an optional hardwired zero register, optional write-to-read
// bypass and optional registered read data. A busy scoreboard marks registers
// that have an instruction issued toward them but not yet written back, so
// decode can detect RAW hazards.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears registers, busy bits and
//              registered read data immediately)
//   readAddr   NUM_READ packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   readData   NUM_READ packed read data,      port i at [i*DATA_W +: DATA_W]
//   readBusy   busy bit of the register addressed by each read port
//   writeEn    write strobe, sampled at posedge clk
//   writeAddr  write destination
//   writeData  write data
//   writeMask  byte enables, bit b covers writeData[8b+7:8b]
//   issueEn    marks issueAddr as pending writeback
//   issueAddr  destination register of the issued instruction
//   busyVec    complete scoreboard, one bit per register
//
// There is no handshake on any port: every strobe takes effect on the edge
// where it is sampled high, and the block never stalls its neighbours.
// ---------------------------------------------------------------------------
module mips_regfile_mp #(
  parameter  int DATA_W   = 32,
  parameter  int DEPTH    = 32,
  parameter  int NUM_READ = 2,
  parameter  int BYPASS   = 1,
  parameter  int READ_REG = 0,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int NBYTES   = DATA_W / 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_READ*ADDR_W-1:0]   readAddr,
  output logic [NUM_READ*DATA_W-1:0]   readData,
  output logic [NUM_READ-1:0]          readBusy,
  input  logic                         writeEn,
  input  logic [ADDR_W-1:0]            writeAddr,
  input  logic [DATA_W-1:0]            writeData,
  input  logic [NBYTES-1:0]            writeMask,
  input  logic                         issueEn,
  input  logic [ADDR_W-1:0]            issueAddr,
  output logic [DEPTH-1:0]             busyVec
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("mips_regfile_mp: DATA_W must be a multiple of 8");
  end
  if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
    $error("mips_regfile_mp: DEPTH must lie in 2..64");
  end
  if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_num_read
    $error("mips_regfile_mp: NUM_READ must lie in 1..4");
  end

  // -------------------------------------------------------------------------
  // Address qualification
  // -------------------------------------------------------------------------
  // An address is in range when it names a physical register. DEPTH need not
  // be a power of two, so the upper codes of ADDR_W can be out of range.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // A usable address is in range and is not the hardwired zero register.
  // Only usable addresses can be written, issued, or return stored data.
  function automatic logic addr_usable(input logic [ADDR_W-1:0] a);
    return addr_in_range(a) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // -------------------------------------------------------------------------
  // Storage and scoreboard state
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic              wr_ok;
  logic              iss_ok;
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_merged;

  assign wr_ok  = writeEn && addr_usable(writeAddr);
  assign iss_ok = issueEn && addr_usable(issueAddr);

  // Current contents of the write target; guarded so an out-of-range code
  // never indexes past the array.
  always_comb begin
    wr_old = '0;
    if (addr_in_range(writeAddr)) begin
      wr_old = mem[writeAddr];
    end
  end

  // Byte merge: masked bytes come from writeData, the rest keep their value.
  // The same merged word feeds the array and the bypass path, so a bypassed
  // read always matches what the register will hold after the edge.
  always_comb begin
    wr_merged = wr_old;
    for (int b = 0; b < NBYTES; b++) begin
      if (writeMask[b]) begin
        wr_merged[8*b +: 8] = writeData[8*b +: 8];
      end
    end
  end

  // Register array. The zero register is never a usable write target, so
  // it stays at its reset value of 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
    end else if (wr_ok) begin
      mem[writeAddr] <= wr_merged;
    end
  end

  // Scoreboard next state. A writeback clears the bit, an issue sets it, and
  // the set is applied last so that a new producer issued on the same edge
  // as the old producer's writeback keeps the register busy. The write clear
  // does not depend on writeMask: a fully masked writeback still retires.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (wr_ok && (writeAddr == ADDR_W'(r))) begin
        busy_d[r] = 1'b0;
      end
      if (iss_ok && (issueAddr == ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busyVec = busy_q;

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_READ; i++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] comb_data;

    assign addr = readAddr[i*ADDR_W +: ADDR_W];

    // Value the port shows without read registering: stored data, replaced
    // by the merged write word when bypass is enabled and the write targets
    // the same register in this cycle.
    always_comb begin
      comb_data = '0;
      if (addr_usable(addr)) begin
        comb_data = mem[addr];
        if ((BYPASS != 0) && wr_ok && (writeAddr == addr)) begin
          comb_data = wr_merged;
        end
      end
    end

    // The busy view is never bypassed. Register 0 under ZERO_REG can never
    // be set, so only the range check is needed here.
    always_comb begin
      readBusy[i] = 1'b0;
      if (addr_in_range(addr)) begin
        readBusy[i] = busy_q[addr];
      end
    end

    if (READ_REG != 0) begin : g_reg
      logic [DATA_W-1:0] data_q;

      // Capturing the combinational value means the capture already holds
      // a write landing on this same edge when bypass is enabled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
        end else begin
          data_q <= comb_data;
        end
      end

      assign readData[i*DATA_W +: DATA_W] = data_q;
    end else begin : g_comb
      assign readData[i*DATA_W +: DATA_W] = comb_data;
    end
  end

  // -------------------------------------------------------------------------
  // Simulation check: register 0 can never be marked busy
  // -------------------------------------------------------------------------
  if (ZERO_REG != 0) begin : g_zero_chk
    always_comb begin
      assert (busy_q[0] == 1'b0)
        else $error("mips_regfile_mp: busy bit of register 0 is set");
    end
  end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// tb_mips_regfile_mp
// ---------------------------------------------------------------------------
// Three register-file instances share one write/issue bus:
//   dut_a : defaults (DEPTH 32, 2 ports, bypass, combinational read, zero reg)
//   dut_b : DEPTH 24 (out-of-range codes 24..31), no bypass
//   dut_c : 3 ports, registered read, no zero register
// A behavioural model (plain arrays, one per configuration) predicts every
// output. Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_mips_regfile_mp;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- shared write / issue bus ----------------
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [3:0]  wm;
  logic        ie;
  logic [4:0]  ia;

  // ---------------- per-instance read side ----------------
  logic [1:0][4:0]  addr_a;
  logic [1:0][31:0] data_a;
  logic [1:0]       rb_a;
  logic [31:0]      bv_a;

  logic [1:0][4:0]  addr_b;
  logic [1:0][31:0] data_b;
  logic [1:0]       rb_b;
  logic [23:0]      bv_b;

  logic [2:0][4:0]  addr_c;
  logic [2:0][31:0] data_c;
  logic [2:0]       rb_c;
  logic [31:0]      bv_c;

  mips_regfile_mp dut_a (
    .clk(clk), .rst_n(rst_n),
    .readAddr(addr_a), .readData(data_a), .readBusy(rb_a),
    .writeEn(we), .writeAddr(wa), .writeData(wd), .writeMask(wm),
    .issueEn(ie), .issueAddr(ia), .busyVec(bv_a)
  );

  mips_regfile_mp #(.DEPTH(24), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .readAddr(addr_b), .readData(data_b), .readBusy(rb_b),
    .writeEn(we), .writeAddr(wa), .writeData(wd), .writeMask(wm),
    .issueEn(ie), .issueAddr(ia), .busyVec(bv_b)
  );

  mips_regfile_mp #(.NUM_READ(3), .READ_REG(1), .ZERO_REG(0)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .readAddr(addr_c), .readData(data_c), .readBusy(rb_c),
    .writeEn(we), .writeAddr(wa), .writeData(wd), .writeMask(wm),
    .issueEn(ie), .issueAddr(ia), .busyVec(bv_c)
  );

  // ---------------- reference model ----------------
  // Index 0/1/2 = configuration of dut_a/dut_b/dut_c.
  logic [31:0] m_mem  [3][32];
  logic        m_busy [3][32];
  logic [31:0] exp_c  [3];

  int checks   = 0;
  int failures = 0;

  function automatic int cfg_depth(int c);
    return (c == 1) ? 24 : 32;
  endfunction

  function automatic bit cfg_zero(int c);
    return c != 2;
  endfunction

  function automatic bit cfg_bypass(int c);
    return c != 1;
  endfunction

  function automatic bit target_ok(int c, int a);
    return (a < cfg_depth(c)) && !(cfg_zero(c) && a == 0);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old);
    logic [31:0] v;
    v = old;
    for (int b = 0; b < 4; b++) begin
      if (wm[b]) v[8*b +: 8] = wd[8*b +: 8];
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_read(int c, int a);
    if (!target_ok(c, a)) return 32'h0;
    if (cfg_bypass(c) && we && int'(wa) == a) return merge(m_mem[c][a]);
    return m_mem[c][a];
  endfunction

  function automatic logic ref_busy(int c, int a);
    if (a >= cfg_depth(c)) return 1'b0;
    return m_busy[c][a];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[c][r]  = 32'h0;
        m_busy[c][r] = 1'b0;
      end
      exp_c[c] = 32'h0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    we = 1'b0; wa = 5'd0; wd = 32'h0; wm = 4'h0;
    ie = 1'b0; ia = 5'd0;
  endtask

  // Advance one rising edge, applying the sampled write/issue to the model;
  // returns 1 time unit after the edge.
  task automatic tick();
    logic [31:0] cap [3];
    @(posedge clk);
    for (int i = 0; i < 3; i++) cap[i] = ref_read(2, int'(addr_c[i]));
    for (int c = 0; c < 3; c++) begin
      if (we && target_ok(c, int'(wa))) begin
        m_mem[c][wa]  = merge(m_mem[c][wa]);
        m_busy[c][wa] = 1'b0;
      end
      if (ie && target_ok(c, int'(ia))) m_busy[c][ia] = 1'b1;
    end
    exp_c = cap;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    addr_a = '0; addr_b = '0; addr_c = '0;
    model_reset();
    #3;
    checks++;
    if (bv_a !== 32'h0 || bv_b !== 24'h0 || bv_c !== 32'h0) begin
      failures++;
      $display("FAIL reset_busy: got a=%h b=%h c=%h expected 0", bv_a, bv_b, bv_c);
    end
    checks++;
    if (data_c !== '0) begin
      failures++;
      $display("FAIL reset_rdata: got %h expected 0", data_c);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Write r5, issue r7, then pull reset mid-cycle.
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; wm = 4'hF;
    ie = 1'b1; ia = 5'd7;
    tick();
    idle();
    addr_a[0] = 5'd5;
    #2;
    checks++;
    if (data_a[0] !== 32'hDEADBEEF || bv_a[7] !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: got data=%h busy7=%b expected deadbeef/1", data_a[0], bv_a[7]);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (data_a[0] !== 32'h0) begin
      failures++;
      $display("FAIL async_reset_data: got %h expected 0", data_a[0]);
    end
    checks++;
    if (bv_a !== 32'h0 || bv_b !== 24'h0 || bv_c !== 32'h0) begin
      failures++;
      $display("FAIL async_reset_busy: got a=%h b=%h c=%h expected 0", bv_a, bv_b, bv_c);
    end
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_byte_mask();
    we = 1'b1; wa = 5'd3; wd = 32'h11223344; wm = 4'hF;
    tick();
    wd = 32'hAABBCCDD; wm = 4'b0101;
    tick();
    idle();
    addr_a[1] = 5'd3; addr_b[0] = 5'd3;
    #2;
    checks++;
    if (data_a[1] !== 32'h11BB33DD || data_b[0] !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL byte_mask: got a=%h b=%h expected 11bb33dd", data_a[1], data_b[0]);
    end
    // A fully masked writeback changes no data but still retires the busy bit.
    ie = 1'b1; ia = 5'd3;
    tick();
    idle();
    #2;
    checks++;
    if (rb_a[1] !== 1'b1) begin
      failures++;
      $display("FAIL mask0_busy_set: got %b expected 1", rb_a[1]);
    end
    we = 1'b1; wa = 5'd3; wd = 32'hFFFFFFFF; wm = 4'h0;
    tick();
    idle();
    #2;
    checks++;
    if (rb_a[1] !== 1'b0 || data_a[1] !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL mask0_write: got busy=%b data=%h expected 0/11bb33dd", rb_a[1], data_a[1]);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 5'd9; wd = 32'h0BADF00D; wm = 4'hF;
    tick();
    wd = 32'h12345678;
    addr_a[0] = 5'd9; addr_b[0] = 5'd9;
    #2;
    checks++;
    if (data_a[0] !== 32'h12345678) begin
      failures++;
      $display("FAIL bypass_on: got %h expected 12345678", data_a[0]);
    end
    checks++;
    if (data_b[0] !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL bypass_off_before: got %h expected 0badf00d", data_b[0]);
    end
    tick();
    idle();
    #2;
    checks++;
    if (data_b[0] !== 32'h12345678) begin
      failures++;
      $display("FAIL bypass_off_after: got %h expected 12345678", data_b[0]);
    end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; wm = 4'hF;
    ie = 1'b1; ia = 5'd0;
    addr_a[0] = 5'd0; addr_c = '0;
    #2;
    checks++;
    if (data_a[0] !== 32'h0) begin
      failures++;
      $display("FAIL zero_bypass: got %h expected 0", data_a[0]);
    end
    tick();
    idle();
    #2;
    checks++;
    if (data_a[0] !== 32'h0 || rb_a[0] !== 1'b0 || bv_a[0] !== 1'b0) begin
      failures++;
      $display("FAIL zero_reg: got data=%h rbusy=%b bv0=%b expected 0/0/0", data_a[0], rb_a[0], bv_a[0]);
    end
    // Without a zero register, r0 behaves as an ordinary register.
    checks++;
    if (data_c[0] !== 32'hFFFFFFFF || bv_c[0] !== 1'b1) begin
      failures++;
      $display("FAIL r0_plain: got data=%h busy=%b expected ffffffff/1", data_c[0], bv_c[0]);
    end
  endtask

  task automatic test_scoreboard();
    ie = 1'b1; ia = 5'd4;
    tick();
    idle();
    addr_a[1] = 5'd4;
    #2;
    checks++;
    if (rb_a[1] !== 1'b1) begin
      failures++;
      $display("FAIL issue_sets_busy: got %b expected 1", rb_a[1]);
    end
    we = 1'b1; wa = 5'd4; wd = 32'h44444444; wm = 4'hF;
    ie = 1'b1; ia = 5'd4;
    tick();
    idle();
    #2;
    checks++;
    if (rb_a[1] !== 1'b1 || bv_a[4] !== 1'b1) begin
      failures++;
      $display("FAIL same_edge_busy: got rb=%b bv=%b expected 1/1", rb_a[1], bv_a[4]);
    end
    we = 1'b1; wa = 5'd4;
    tick();
    idle();
    #2;
    checks++;
    if (rb_a[1] !== 1'b0 || bv_a[4] !== 1'b0) begin
      failures++;
      $display("FAIL write_clears_busy: got rb=%b bv=%b expected 0/0", rb_a[1], bv_a[4]);
    end
    // Code 26 is a real register for dut_a and out of range for dut_b.
    we = 1'b1; wa = 5'd26; wd = 32'h5A5A5A5A; wm = 4'hF;
    ie = 1'b1; ia = 5'd26;
    tick();
    idle();
    addr_a[0] = 5'd26; addr_b[1] = 5'd26;
    #2;
    checks++;
    if (data_b[1] !== 32'h0 || rb_b[1] !== 1'b0 || bv_b !== 24'h0) begin
      failures++;
      $display("FAIL invalid_addr: got data=%h rb=%b bv=%h expected 0/0/0", data_b[1], rb_b[1], bv_b);
    end
    checks++;
    if (data_a[0] !== 32'h5A5A5A5A || rb_a[0] !== 1'b1) begin
      failures++;
      $display("FAIL valid_addr26: got data=%h rb=%b expected 5a5a5a5a/1", data_a[0], rb_a[0]);
    end
  endtask

  task automatic test_registered();
    addr_c[0] = 5'd2; addr_c[1] = 5'd2; addr_c[2] = 5'd2;
    tick();
    we = 1'b1; wa = 5'd2; wd = 32'hCAFE0001; wm = 4'hF;
    #2;
    checks++;
    if (data_c[0] !== 32'h0 || data_c[1] !== 32'h0 || data_c[2] !== 32'h0) begin
      failures++;
      $display("FAIL rreg_before: got %h expected all 0", data_c);
    end
    tick();
    idle();
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (data_c[i] !== 32'hCAFE0001) begin
        failures++;
        $display("FAIL rreg_capture port%0d: got %h expected cafe0001", i, data_c[i]);
      end
    end
    // Address change takes exactly one edge to show.
    addr_c[0] = 5'd3;
    #2;
    checks++;
    if (data_c[0] !== 32'hCAFE0001) begin
      failures++;
      $display("FAIL rreg_hold: got %h expected cafe0001", data_c[0]);
    end
    tick();
    #2;
    checks++;
    if (data_c[0] !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL rreg_latency: got %h expected 11bb33dd", data_c[0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] eb_a;
    logic [23:0] eb_b;
    logic [31:0] eb_c;
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom_range(0, 1));
      wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wd = $urandom;
      wm = 4'($urandom_range(0, 15));
      ie = ($urandom_range(0, 2) == 0);
      ia = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      for (int i = 0; i < 2; i++) begin
        addr_a[i] = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31));
        addr_b[i] = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31));
      end
      for (int i = 0; i < 3; i++) addr_c[i] = 5'($urandom_range(0, 31));
      if (n == 200) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
      end
      #2;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (data_a[i] !== ref_read(0, int'(addr_a[i])) || rb_a[i] !== ref_busy(0, int'(addr_a[i]))) begin
          failures++;
          $display("FAIL rand_a n=%0d port%0d addr=%0d: got %h/%b expected %h/%b", n, i, addr_a[i],
                   data_a[i], rb_a[i], ref_read(0, int'(addr_a[i])), ref_busy(0, int'(addr_a[i])));
        end
        checks++;
        if (data_b[i] !== ref_read(1, int'(addr_b[i])) || rb_b[i] !== ref_busy(1, int'(addr_b[i]))) begin
          failures++;
          $display("FAIL rand_b n=%0d port%0d addr=%0d: got %h/%b expected %h/%b", n, i, addr_b[i],
                   data_b[i], rb_b[i], ref_read(1, int'(addr_b[i])), ref_busy(1, int'(addr_b[i])));
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (data_c[i] !== exp_c[i] || rb_c[i] !== ref_busy(2, int'(addr_c[i]))) begin
          failures++;
          $display("FAIL rand_c n=%0d port%0d: got %h/%b expected %h/%b", n, i,
                   data_c[i], rb_c[i], exp_c[i], ref_busy(2, int'(addr_c[i])));
        end
      end
      for (int r = 0; r < 32; r++) begin
        eb_a[r] = m_busy[0][r];
        eb_c[r] = m_busy[2][r];
      end
      for (int r = 0; r < 24; r++) eb_b[r] = m_busy[1][r];
      checks++;
      if (bv_a !== eb_a || bv_b !== eb_b || bv_c !== eb_c) begin
        failures++;
        $display("FAIL rand_busyvec n=%0d: got %h/%h/%h expected %h/%h/%h", n,
                 bv_a, bv_b, bv_c, eb_a, eb_b, eb_c);
      end
      tick();
    end
    idle();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_byte_mask();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_registered();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
